// File: rtl/vel_filter_pkg.sv
// Shared types and default sizing for the velocity filter scheduler.
package vel_filter_pkg;

  localparam int VF_NUM_CH = 4;
  localparam int VF_WIDTH  = 16;
  localparam int VF_SHIFT  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    WRITE   = 2'd3
  } vf_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after pointer, wrapping.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  pointer,
  output logic [NUM_CH-1:0] grant_onehot,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              any
);

  int c;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    c            = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      c = (int'(pointer) + k) % NUM_CH;
      if (!any && req[c]) begin
        any             = 1'b1;
        grant_idx       = IDX_W'(c);
        grant_onehot[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/velocity_filter_scheduler.sv
// Time-shared first-order velocity filter across NUM_CH channels, round-robin scheduled.
// Optional VEL_FILTER_PRIME_EN: first sample per channel loads raw directly.
module velocity_filter_scheduler
  import vel_filter_pkg::*;
#(
  parameter int NUM_CH = VF_NUM_CH,
  parameter int WIDTH  = VF_WIDTH,
  parameter int SHIFT  = VF_SHIFT,
  localparam int IDX_W = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       req,
  input  logic [NUM_CH*WIDTH-1:0] raw_velocity,
  output logic [NUM_CH-1:0]       ack,
  output logic                    filtered_valid,
  output logic [IDX_W-1:0]        filtered_channel,
  output logic [WIDTH-1:0]        filtered_velocity,
  output logic                    busy
);

  vf_state_e                   state;
  logic [IDX_W-1:0]            ptr;
  logic [IDX_W-1:0]            cur_idx;
  logic [IDX_W-1:0]            grant_idx;
  logic [IDX_W-1:0]            ptr_next;
  logic [NUM_CH-1:0]           grant_onehot;
  logic                        any;
  logic [NUM_CH-1:0][WIDTH-1:0] chan_state;
  logic [NUM_CH-1:0][WIDTH-1:0] raw_lanes;
  logic [WIDTH-1:0]            raw_q;
  logic [WIDTH-1:0]            last_q;
  logic [WIDTH-1:0]            filt;
  logic [WIDTH-1:0]            new_val;

  assign raw_lanes = raw_velocity;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req          (req),
    .pointer      (ptr),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any          (any)
  );

  assign ptr_next = (grant_idx == IDX_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;

  // The step is taken in WIDTH+1 signed bits; |step| <= |raw-last| so the sum
  // always lands between last and raw and fits back in WIDTH bits.
  always_comb begin
    filt = WIDTH'($signed({1'b0, last_q})
                  + (($signed({1'b0, raw_q}) - $signed({1'b0, last_q})) >>> SHIFT));
  end

`ifdef VEL_FILTER_PRIME_EN
  logic [NUM_CH-1:0] primed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                primed          <= '0;
    else if (state == COMPUTE) primed[cur_idx] <= 1'b1;
  end

  assign new_val = primed[cur_idx] ? filt : raw_q;
`else
  assign new_val = filt;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      ptr               <= '0;
      cur_idx           <= '0;
      raw_q             <= '0;
      last_q            <= '0;
      chan_state        <= '0;
      ack               <= '0;
      filtered_valid    <= 1'b0;
      filtered_channel  <= '0;
      filtered_velocity <= '0;
      busy              <= 1'b0;
    end else begin
      ack            <= '0;
      filtered_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            state   <= LOAD;
            busy    <= 1'b1;
            ack     <= grant_onehot;
            cur_idx <= grant_idx;
            raw_q   <= raw_lanes[grant_idx];
            last_q  <= chan_state[grant_idx];
            ptr     <= ptr_next;
          end
        end
        LOAD: state <= COMPUTE;
        COMPUTE: begin
          state               <= WRITE;
          chan_state[cur_idx] <= new_val;
          filtered_velocity   <= new_val;
          filtered_channel    <= cur_idx;
          filtered_valid      <= 1'b1;
        end
        WRITE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_velocity_filter_scheduler.sv
// Self-checking bench: table vectors, corner sequences and randomized traffic vs a transaction model.
module tb_velocity_filter_scheduler;

  localparam int N = 4;
  localparam int W = 16;
  localparam int S = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] raw_velocity;
  logic [N-1:0]   ack;
  logic           filtered_valid;
  logic [1:0]     filtered_channel;
  logic [W-1:0]   filtered_velocity;
  logic           busy;

  logic [W-1:0]   raw_arr [N];

  always #5 clk = ~clk;

  always_comb begin
    raw_velocity = '0;
    for (int i = 0; i < N; i++) raw_velocity[i*W +: W] = raw_arr[i];
  end

  velocity_filter_scheduler #(.NUM_CH(N), .WIDTH(W), .SHIFT(S)) dut (
    .clk               (clk),
    .reset             (reset),
    .req               (req),
    .raw_velocity      (raw_velocity),
    .ack               (ack),
    .filtered_valid    (filtered_valid),
    .filtered_channel  (filtered_channel),
    .filtered_velocity (filtered_velocity),
    .busy              (busy)
  );

  int n_pass, n_total, cyc;

  // transaction-level reference: cycles since grant, per-channel filter state
  int       m_phase, m_ch, m_ptr, m_raw;
  int       m_state [N];
  bit       m_primed [N];
  logic [N-1:0] e_ack;
  bit       e_valid, e_busy;
  int       e_fch, e_fvel;

  task automatic chk(string nm, longint act, longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic int filt_ref(int last, int raw);
    int d;
    d = raw - last;
    return last + (d >>> S);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_ch = 0; m_ptr = 0; m_raw = 0;
    for (int i = 0; i < N; i++) begin m_state[i] = 0; m_primed[i] = 0; end
    e_ack = '0; e_valid = 0; e_busy = 0; e_fch = 0; e_fvel = 0;
  endtask

  task automatic model_edge();
    bit found;
    int res;
    if (reset) begin model_reset(); return; end
    e_ack = '0; e_valid = 0; found = 0; res = 0;
    case (m_phase)
      0: begin
        for (int k = 0; k < N; k++)
          if (!found && req[(m_ptr + k) % N]) begin found = 1; m_ch = (m_ptr + k) % N; end
        if (found) begin
          m_raw = int'(raw_arr[m_ch]);
          e_ack[m_ch] = 1'b1;
          m_ptr = (m_ch + 1) % N;
          m_phase = 1;
        end
      end
      1: m_phase = 2;
      2: begin
        res = filt_ref(m_state[m_ch], m_raw);
`ifdef VEL_FILTER_PRIME_EN
        if (!m_primed[m_ch]) res = m_raw;
        m_primed[m_ch] = 1;
`endif
        m_state[m_ch] = res;
        e_valid = 1; e_fch = m_ch; e_fvel = res;
        m_phase = 3;
      end
      default: m_phase = 0;
    endcase
    e_busy = (m_phase != 0);
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    chk("ack", ack, e_ack);
    chk("valid", filtered_valid, e_valid);
    chk("busy", busy, e_busy);
    chk("fch", filtered_channel, e_fch);
    chk("fvel", filtered_velocity, e_fvel);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic run_txn(input int ch, input logic [W-1:0] raw,
                         output logic [W-1:0] vel, output int gch, output bit got);
    raw_arr[ch] = raw;
    req = '0;
    req[ch] = 1'b1;
    got = 0; vel = '0; gch = -1;
    for (int t = 0; t < 20 && !got; t++) begin
      cycle();
      if (ack[ch]) req[ch] = 1'b0;
      if (filtered_valid) begin got = 1; vel = filtered_velocity; gch = int'(filtered_channel); end
    end
  endtask

  typedef struct {
    int         ch;
    logic [W-1:0] raw;
    logic [W-1:0] exp_vel;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [W-1:0] vel, prev;
    int gch, acks3, nvalid;
    bit got;
    int order[$];
    int vtimes[$];

    n_pass = 0; n_total = 0; cyc = 0;
    for (int i = 0; i < N; i++) raw_arr[i] = '0;
    req = '0;
    reset = 1'b1;
    model_reset();

`ifdef VEL_FILTER_PRIME_EN
    tbl[0] = '{0, 16'h1000, 16'h1000};
    tbl[1] = '{1, 16'h8000, 16'h8000};
    tbl[2] = '{1, 16'h0000, 16'h7800};
    tbl[3] = '{0, 16'h0000, 16'h0F00};
    tbl[4] = '{2, 16'hFFFF, 16'hFFFF};
    tbl[5] = '{0, 16'h0005, 16'h0E10};
`else
    tbl[0] = '{0, 16'h1000, 16'h0100};
    tbl[1] = '{1, 16'h8000, 16'h0800};
    tbl[2] = '{1, 16'h0000, 16'h0780};
    tbl[3] = '{0, 16'h0000, 16'h00F0};
    tbl[4] = '{2, 16'hFFFF, 16'h0FFF};
    tbl[5] = '{0, 16'h0005, 16'h00E1};
`endif

    // reset state
    do_reset();

    // single-channel vectors with hand-computed results
    for (int v = 0; v < 6; v++) begin
      run_txn(tbl[v].ch, tbl[v].raw, vel, gch, got);
      chk("tbl_seen", got, 1);
      chk("tbl_ch", gch, tbl[v].ch);
      chk("tbl_vel", vel, tbl[v].exp_vel);
    end
    cycle();

    // all requesters held: rotation and 4-cycle spacing
    do_reset();
    for (int i = 0; i < N; i++) raw_arr[i] = 16'(16'h1111 * (i + 1));
    req = 4'hF;
    for (int t = 0; t < 22; t++) begin
      cycle();
      for (int i = 0; i < N; i++) if (ack[i]) order.push_back(i);
      if (filtered_valid) vtimes.push_back(cyc);
    end
    req = '0;
    for (int k = 0; k < 5; k++) chk("rr_order", (k < order.size()) ? order[k] : -1, k % N);
    for (int k = 1; k < 4; k++)
      chk("rr_spacing", (k < vtimes.size()) ? vtimes[k] - vtimes[k-1] : -1, 4);
    cycle(); cycle(); cycle(); cycle();

    // long saturation run on ch2
    do_reset();
    raw_arr[2] = 16'hFFFF;
    req = 4'b0100;
    prev = '0; nvalid = 0;
    for (int t = 0; t < 1000 && nvalid < 200; t++) begin
      cycle();
      if (filtered_valid) begin
        chk("mono", (filtered_velocity >= prev) ? 1 : 0, 1);
        prev = filtered_velocity;
        nvalid++;
      end
    end
    req = '0;
    chk("sat_count", nvalid, 200);
    chk("sat_conv", (prev >= 16'hFFF0) ? 1 : 0, 1);
    cycle(); cycle(); cycle(); cycle();

    // reset during COMPUTE aborts and clears state
    do_reset();
    run_txn(1, 16'h1000, vel, gch, got);
    cycle();
    raw_arr[1] = 16'h2000;
    req = 4'b0010;
    got = 0;
    for (int t = 0; t < 10 && !got; t++) begin cycle(); if (ack[1]) got = 1; end
    chk("abort_ack", got, 1);
    req = '0;
    cycle();
    reset = 1'b1;
    model_reset();
    #1;
    chk("abort_valid", filtered_valid, 0);
    chk("abort_busy", busy, 0);
    cycle(); cycle();
    reset = 1'b0;
    nvalid = 0;
    for (int t = 0; t < 4; t++) begin cycle(); if (filtered_valid) nvalid++; end
    chk("abort_no_valid", nvalid, 0);
    run_txn(1, 16'h1000, vel, gch, got);
    chk("abort_seen", got, 1);
`ifdef VEL_FILTER_PRIME_EN
    chk("abort_vel", vel, 16'h1000);
`else
    chk("abort_vel", vel, 16'h0100);
`endif

    // req[3] pulsed only while busy
    cycle();
    acks3 = 0;
    raw_arr[0] = 16'h3000;
    req = 4'b0001;
    got = 0;
    for (int t = 0; t < 10 && !got; t++) begin cycle(); if (ack[0]) got = 1; end
    req = '0;
    cycle();
    req[3] = 1'b1;
    raw_arr[3] = 16'h7777;
    cycle();
    if (ack[3] || (filtered_valid && filtered_channel == 2'd3)) acks3++;
    req[3] = 1'b0;
    for (int t = 0; t < 8; t++) begin
      cycle();
      if (ack[3] || (filtered_valid && filtered_channel == 2'd3)) acks3++;
    end
    chk("pulse_ignored", acks3, 0);

    // randomized traffic against the model
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) raw_arr[i] = 16'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
